gte_mac_seq: RTL
================

GTE_MAC_SEQ -- requirements
Module: gte_mac_seq

Interface
REQ-001 The block SHALL have no parameters.
REQ-002 i_clk  in  1  sole clock, all state updates on rising edge.
REQ-003 i_rst  in  1  asynchronous, active-high reset.
REQ-004 i_start  in  1  one-cycle command strobe, sampled only in IDLE.
REQ-005 i_mx  in  2  matrix select (0=rot, 1=light, 2=color, 3=garbage matrix).
REQ-006 i_v  in  2  multiply vector select (0..2=V0..V2, 3=IR).
REQ-007 i_cv  in  2  translation select (0=TR, 1=BK, 2=FC, 3=none).
REQ-008 i_sf, i_lm  in  1 each  shift-12 and saturate-low-limit flags.
REQ-009 i_stall  in  1  freeze request from downstream datapath.
REQ-010 o_busy, o_done  out  1 each  command active; one-cycle completion pulse.
REQ-011 o_mat  out  2; o_vec  out  2; o_comp  out  2  mux selects to the select path.
REQ-012 o_selLeft  out  3; o_selRight  out  4  left/right operand selects.
REQ-013 o_accLoad, o_accClr, o_accEn  out  1 each  accumulator load-translation, clear, add-product strobes.
REQ-014 o_trSel  out  2; o_row  out  2; o_wrRow  out  1; o_sf, o_lm  out  1 each  translation select, current row, row write-back strobe, latched flags.

Function
REQ-015 States SHALL be IDLE, TRANS, MAC, WB, DONE; internal counters row (0..2) and col (0..2).
REQ-016 IDLE + i_start=1 SHALL latch mx, v, cv, sf, lm, set row=0, col=0, enter TRANS next cycle; o_busy=1 from that cycle.
REQ-017 TRANS (1 cycle): cv!=3 -> o_accLoad=1, o_trSel=cv; cv=3 -> o_accClr=1; next state MAC.
REQ-018 MAC (3 cycles, col 0,1,2): o_accEn=1, o_selLeft=col, o_selRight=0, o_comp=col, o_mat=latched mx, o_vec=latched v; after col=2 -> WB, col=0.
REQ-019 WB (1 cycle): o_wrRow=1, o_row=row; row<2 -> row+1, TRANS; row=2 -> DONE.
REQ-020 DONE (1 cycle): o_done=1, o_busy=0; next IDLE; o_busy SHALL be 0 in IDLE and DONE, 1 in TRANS/MAC/WB.
REQ-021 A command SHALL take exactly 15 busy cycles (3 x (1+3+1)); o_done SHALL assert on the 16th cycle after the start-sampling edge.
REQ-022 i_start while not IDLE SHALL be ignored; no queuing.
REQ-023 i_stall=1 in TRANS/MAC/WB SHALL hold state, row, col and SHALL force o_accLoad, o_accClr, o_accEn, o_wrRow to 0 that cycle; selects SHALL stay driven with held values.
REQ-024 i_stall SHALL have no effect in IDLE or DONE; o_done SHALL never be delayed by stall.
REQ-025 o_sf, o_lm SHALL reflect latched flags throughout busy and DONE cycles.
REQ-026 Outside MAC, o_selLeft, o_selRight, o_comp SHALL be 0; o_mat, o_vec hold latched values.
REQ-027 o_row SHALL equal the row counter in all busy states.

Reset
REQ-028 i_rst=1 SHALL immediately force IDLE, row=0, col=0, all latched fields 0, all outputs 0, irrespective of clock.
REQ-029 Reset mid-command SHALL abort with no o_done and no further o_wrRow.
REQ-030 First i_start after reset deassertion SHALL be honoured on the first rising edge.

Configuration
REQ-031 Macro GTE_SEQ_ABORT_EN defined: input i_abort (1 bit) SHALL exist; i_abort=1 in any busy state SHALL return to IDLE next cycle, suppress all strobes that cycle, emit no o_done; i_abort takes priority over i_stall.
REQ-032 GTE_SEQ_ABORT_EN undefined: no i_abort port; commands always run to DONE unless reset.

Verification
REQ-033 Start mx=0,v=1,cv=0,sf=1 no stall -> o_accLoad at cycles 1,6,11, o_wrRow at cycles 5,10,15 with o_row 0,1,2, o_done at cycle 16, o_busy 1 for cycles 1-15.
REQ-034 Start cv=3 -> o_accClr (not o_accLoad) at cycles 1,6,11; o_trSel unused; timing as REQ-033.
REQ-035 i_stall=1 for 4 cycles during row 1 col 1 -> o_done moves from cycle 16 to 20, no strobes during stall, o_selLeft held at 1.
REQ-036 i_start pulsed at cycle 7 of a running command -> ignored, single o_done, o_mat unchanged.
REQ-037 i_rst asserted at cycle 8 -> outputs 0 without waiting for a clock edge, no o_done, next i_start runs a full 15-cycle command.
REQ-038 With GTE_SEQ_ABORT_EN, i_abort at cycle 9 with i_stall=1 -> IDLE at cycle 10, o_busy=0, no o_wrRow for row 1, no o_done.

Source files
------------

// File: rtl/gte_mac_seq_if.sv
// gte_mac_seq_if
//   Command and select bundle between the GTE command sequencer and its
//   surroundings.
//   Optional feature macro: GTE_SEQ_ABORT_EN adds the i_abort input.
//
//   Command side (into the sequencer):
//     i_start, i_mx, i_v, i_cv, i_sf, i_lm, i_stall, [i_abort]
//   Select side (out of the sequencer):
//     o_busy, o_done, o_mat, o_vec, o_comp, o_selLeft, o_selRight,
//     o_accLoad, o_accClr, o_accEn, o_trSel, o_row, o_wrRow, o_sf, o_lm
//
//   Modports:
//     slave  - the sequencer itself
//     master - whoever issues commands and consumes the selects
interface gte_mac_seq_if;
    logic       i_start;
    logic [1:0] i_mx;
    logic [1:0] i_v;
    logic [1:0] i_cv;
    logic       i_sf;
    logic       i_lm;
    logic       i_stall;
`ifdef GTE_SEQ_ABORT_EN
    logic       i_abort;
`endif
    logic       o_busy;
    logic       o_done;
    logic [1:0] o_mat;
    logic [1:0] o_vec;
    logic [1:0] o_comp;
    logic [2:0] o_selLeft;
    logic [3:0] o_selRight;
    logic       o_accLoad;
    logic       o_accClr;
    logic       o_accEn;
    logic [1:0] o_trSel;
    logic [1:0] o_row;
    logic       o_wrRow;
    logic       o_sf;
    logic       o_lm;

    modport slave (
        input  i_start, i_mx, i_v, i_cv, i_sf, i_lm, i_stall,
`ifdef GTE_SEQ_ABORT_EN
        input  i_abort,
`endif
        output o_busy, o_done, o_mat, o_vec, o_comp, o_selLeft, o_selRight,
               o_accLoad, o_accClr, o_accEn, o_trSel, o_row, o_wrRow, o_sf, o_lm
    );

    modport master (
        output i_start, i_mx, i_v, i_cv, i_sf, i_lm, i_stall,
`ifdef GTE_SEQ_ABORT_EN
        output i_abort,
`endif
        input  o_busy, o_done, o_mat, o_vec, o_comp, o_selLeft, o_selRight,
               o_accLoad, o_accClr, o_accEn, o_trSel, o_row, o_wrRow, o_sf, o_lm
    );
endinterface

// File: rtl/gte_mac_seq.sv
// gte_mac_seq
//   Command sequencer for a GTE matrix-vector multiply-accumulate. For each
//   of three rows it loads (or clears) the accumulator with a translation,
//   adds three column products, then writes the row back.
//   Per command: 3 x (TRANS + 3 MAC + WB) = 15 busy cycles, then DONE.
//   Optional feature macro: GTE_SEQ_ABORT_EN (adds bus.i_abort; an abort in
//   any busy state returns to IDLE with no strobes and no done pulse).
//
//   Ports:
//     i_clk  - clock, rising edge
//     i_rst  - asynchronous active-high reset
//     bus    - gte_mac_seq_if.slave: command inputs, stall, select outputs
module gte_mac_seq (
    input  logic          i_clk,
    input  logic          i_rst,
    gte_mac_seq_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_TRANS = 3'd1,
        S_MAC   = 3'd2,
        S_WB    = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] row_q, row_d;
    logic [1:0] col_q, col_d;
    logic [1:0] mx_q, mx_d;
    logic [1:0] v_q, v_d;
    logic [1:0] cv_q, cv_d;
    logic       sf_q, sf_d;
    logic       lm_q, lm_d;

    logic abort;
    logic go;

`ifdef GTE_SEQ_ABORT_EN
    assign abort = bus.i_abort;
`else
    assign abort = 1'b0;
`endif

    // A busy state advances only when neither stalled nor aborted.
    assign go = !bus.i_stall && !abort;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_IDLE;
            row_q   <= 2'd0;
            col_q   <= 2'd0;
            mx_q    <= 2'd0;
            v_q     <= 2'd0;
            cv_q    <= 2'd0;
            sf_q    <= 1'b0;
            lm_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            mx_q    <= mx_d;
            v_q     <= v_d;
            cv_q    <= cv_d;
            sf_q    <= sf_d;
            lm_q    <= lm_d;
        end
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        mx_d    = mx_q;
        v_d     = v_q;
        cv_d    = cv_q;
        sf_d    = sf_q;
        lm_d    = lm_q;

        bus.o_busy     = 1'b0;
        bus.o_done     = 1'b0;
        bus.o_mat      = mx_q;
        bus.o_vec      = v_q;
        bus.o_comp     = 2'd0;
        bus.o_selLeft  = 3'd0;
        bus.o_selRight = 4'd0;
        bus.o_accLoad  = 1'b0;
        bus.o_accClr   = 1'b0;
        bus.o_accEn    = 1'b0;
        bus.o_trSel    = 2'd0;
        bus.o_row      = row_q;
        bus.o_wrRow    = 1'b0;
        bus.o_sf       = sf_q;
        bus.o_lm       = lm_q;

        case (state_q)
            S_IDLE: begin
                if (bus.i_start) begin
                    mx_d    = bus.i_mx;
                    v_d     = bus.i_v;
                    cv_d    = bus.i_cv;
                    sf_d    = bus.i_sf;
                    lm_d    = bus.i_lm;
                    row_d   = 2'd0;
                    col_d   = 2'd0;
                    state_d = S_TRANS;
                end
            end
            S_TRANS: begin
                bus.o_busy = 1'b1;
                // cv == 3 means "no translation": start the row from zero.
                if (cv_q != 2'd3) begin
                    bus.o_trSel   = cv_q;
                    bus.o_accLoad = go;
                end else begin
                    bus.o_accClr  = go;
                end
                if (go) state_d = S_MAC;
            end
            S_MAC: begin
                bus.o_busy    = 1'b1;
                bus.o_selLeft = {1'b0, col_q};
                bus.o_comp    = col_q;
                bus.o_accEn   = go;
                if (go) begin
                    if (col_q == 2'd2) begin
                        col_d   = 2'd0;
                        state_d = S_WB;
                    end else begin
                        col_d   = col_q + 2'd1;
                    end
                end
            end
            S_WB: begin
                bus.o_busy  = 1'b1;
                bus.o_wrRow = go;
                if (go) begin
                    if (row_q == 2'd2) begin
                        state_d = S_DONE;
                    end else begin
                        row_d   = row_q + 2'd1;
                        state_d = S_TRANS;
                    end
                end
            end
            S_DONE: begin
                // Stall is deliberately ignored here so done is never late.
                bus.o_done = 1'b1;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort beats stall and drops the command without a done pulse.
        if (abort && (state_q == S_TRANS || state_q == S_MAC || state_q == S_WB)) begin
            state_d = S_IDLE;
            row_d   = 2'd0;
            col_d   = 2'd0;
        end
    end

endmodule
